// File: rtl/even_count_monitor.sv
// Checker for an even up-counter bus: locks onto the +STEP sequence and flags
// odd values, sequence breaks and wrap-around with registered one-cycle pulses.
module even_count_monitor #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned STEP       = 2,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid,
    input  logic [WIDTH-1:0]     q,
    input  logic                 clr_err,
    output logic                 locked,
    output logic [WIDTH-1:0]     expected,
    output logic                 odd_err,
    output logic                 seq_err,
    output logic                 err_pulse,
    output logic                 wrap_pulse,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int unsigned McW = $clog2(LOCK_COUNT + 1);
    localparam logic [WIDTH-1:0] StepW = WIDTH'(STEP);
    // Last value before the counter rolls over: 2^WIDTH - STEP.
    localparam logic [WIDTH-1:0] WrapVal = -StepW;
    localparam logic [McW-1:0] LockCnt = McW'(LOCK_COUNT);
    localparam logic [ERR_CNT_W-1:0] ErrMax = '1;

    typedef enum logic [1:0] {StHunt, StConfirm, StLocked} state_e;

    state_e                 state_q, state_d;
    logic [WIDTH-1:0]       exp_q, exp_d;
    logic [McW-1:0]         mc_q, mc_d;
    logic                   odd_d, seq_d, err_d, wrap_d;
    logic                   odd_q, seq_q, err_q, wrap_q;
    logic [ERR_CNT_W-1:0]   cnt_q, cnt_d;
    logic [McW-1:0]         mc_inc;

    assign mc_inc = mc_q + McW'(1);

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        mc_d    = mc_q;
        odd_d   = 1'b0;
        seq_d   = 1'b0;
        err_d   = 1'b0;
        wrap_d  = 1'b0;
        if (valid) begin
            unique case (state_q)
                StHunt: begin
                    if (q[0]) begin
                        odd_d = 1'b1;
                    end else begin
                        exp_d   = q + StepW;
                        mc_d    = McW'(1);
                        state_d = StConfirm;
                    end
                end
                StConfirm: begin
                    if (q[0]) begin
                        odd_d   = 1'b1;
                        mc_d    = '0;
                        state_d = StHunt;
                    end else if (q == exp_q) begin
                        exp_d = exp_q + StepW;
                        mc_d  = mc_inc;
                        if (mc_inc == LockCnt) begin
                            state_d = StLocked;
                        end
                    end else begin
                        exp_d = q + StepW;
                        mc_d  = McW'(1);
                    end
                end
                StLocked: begin
                    if (q[0]) begin
                        odd_d   = 1'b1;
                        err_d   = 1'b1;
                        mc_d    = '0;
                        state_d = StHunt;
                    end else if (q == exp_q) begin
                        exp_d  = exp_q + StepW;
                        wrap_d = (q == WrapVal);
                    end else begin
                        seq_d   = 1'b1;
                        err_d   = 1'b1;
                        exp_d   = q + StepW;
                        mc_d    = McW'(1);
                        state_d = StConfirm;
                    end
                end
                default: state_d = StHunt;
            endcase
        end
    end

    // Clear wins over a simultaneous error; the pulses themselves still fire.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_err) begin
            cnt_d = '0;
        end else if (err_d && cnt_q != ErrMax) begin
            cnt_d = cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StHunt;
            exp_q   <= '0;
            mc_q    <= '0;
            odd_q   <= 1'b0;
            seq_q   <= 1'b0;
            err_q   <= 1'b0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            mc_q    <= mc_d;
            odd_q   <= odd_d;
            seq_q   <= seq_d;
            err_q   <= err_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
        end
    end

    assign locked     = (state_q == StLocked);
    assign expected   = exp_q;
    assign odd_err    = odd_q;
    assign seq_err    = seq_q;
    assign err_pulse  = err_q;
    assign wrap_pulse = wrap_q;
    assign err_count  = cnt_q;

endmodule

// File: tb/tb_even_count_monitor.sv
// Directed bench for even_count_monitor; a second instance with a 2-bit error
// counter covers saturation and clear priority.
module tb_even_count_monitor;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] q = '0;
    logic       clr_err = 1'b0;

    logic       locked, odd_err, seq_err, err_pulse, wrap_pulse;
    logic [7:0] expected, err_count;
    logic       locked2, odd_err2, seq_err2, err_pulse2, wrap_pulse2;
    logic [7:0] expected2;
    logic [1:0] err_count2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    even_count_monitor dut (
        .clk(clk), .reset(reset), .valid(valid), .q(q), .clr_err(clr_err),
        .locked(locked), .expected(expected), .odd_err(odd_err), .seq_err(seq_err),
        .err_pulse(err_pulse), .wrap_pulse(wrap_pulse), .err_count(err_count)
    );

    even_count_monitor #(.ERR_CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .valid(valid), .q(q), .clr_err(clr_err),
        .locked(locked2), .expected(expected2), .odd_err(odd_err2), .seq_err(seq_err2),
        .err_pulse(err_pulse2), .wrap_pulse(wrap_pulse2), .err_count(err_count2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got %0d want %0d", tag, got, want);
        end
    endtask

    // Drive one sample at the falling edge; return just after the sampling edge.
    task automatic sample(input logic [7:0] qv, input logic clr = 1'b0);
        @(negedge clk);
        valid   = 1'b1;
        q       = qv;
        clr_err = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        valid   = 1'b0;
        clr_err = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic feed4(input logic [7:0] base);
        for (int i = 0; i < 4; i++) sample(base + 8'(2 * i));
    endtask

    initial begin
        // 1: reset state and first lock
        do_reset();
        check("rst_locked", locked, 0);
        check("rst_expected", expected, 0);
        check("rst_err_count", err_count, 0);
        sample(0); sample(2); sample(4);
        check("t1_not_yet_locked", locked, 0);
        sample(6);
        check("t1_locked", locked, 1);
        check("t1_expected", expected, 8);
        check("t1_no_err", {odd_err, seq_err, err_pulse, wrap_pulse}, 0);
        check("t1_err_count", err_count, 0);

        // 2: wrap-around while locked
        do_reset();
        feed4(242);
        check("t2_locked", locked, 1);
        check("t2_expected", expected, 250);
        sample(250);
        check("t2_no_wrap_250", wrap_pulse, 0);
        sample(252);
        sample(254);
        check("t2_wrap_254", wrap_pulse, 1);
        check("t2_expected_0", expected, 0);
        sample(0);
        check("t2_wrap_cleared", wrap_pulse, 0);
        sample(2);
        check("t2_still_locked", locked, 1);
        check("t2_expected_4", expected, 4);

        // 3: skipped step, then relock
        for (int v = 4; v <= 18; v += 2) sample(8'(v));
        check("t3_expected_20", expected, 20);
        sample(24);
        check("t3_seq_err", seq_err, 1);
        check("t3_err_pulse", err_pulse, 1);
        check("t3_err_count", err_count, 1);
        check("t3_unlocked", locked, 0);
        check("t3_reseed", expected, 26);
        idle();
        check("t3_pulse_one_cycle", {seq_err, err_pulse}, 0);
        sample(26); sample(28);
        check("t3_confirming", locked, 0);
        sample(30);
        check("t3_relocked", locked, 1);
        check("t3_expected_32", expected, 32);

        // 4: odd value while locked, then while hunting
        sample(9);
        check("t4_odd_locked", odd_err, 1);
        check("t4_err_pulse_locked", err_pulse, 1);
        check("t4_count_locked", err_count, 2);
        check("t4_to_hunt", locked, 0);
        sample(7);
        check("t4_odd_hunt", odd_err, 1);
        check("t4_no_err_pulse_hunt", err_pulse, 0);
        check("t4_count_hunt", err_count, 2);
        check("t4_expected_held", expected, 32);

        // 5: asynchronous reset while locked with three errors counted
        feed4(40);
        sample(50);
        check("t5_third_err", err_count, 3);
        sample(52); sample(54); sample(56);
        check("t5_locked", locked, 1);
        check("t5_count3", err_count, 3);
        sample(58);
        #2;
        reset = 1'b0;
        #1;
        check("t5_async_outs",
              {locked, odd_err, seq_err, err_pulse, wrap_pulse, expected, err_count}, 0);
        @(negedge clk);
        valid = 1'b0;
        reset = 1'b1;
        feed4(0);
        check("t5_relocked", locked, 1);
        check("t5_expected_8", expected, 8);

        // 6: saturating 2-bit counter and clear priority
        do_reset();
        feed4(0);
        check("t6_locked", locked2, 1);
        for (int i = 0; i < 5; i++) begin
            sample(8'd1);
            check($sformatf("t6_count_%0d", i), err_count2, (i < 3) ? i + 1 : 3);
            feed4(0);
        end
        check("t6_saturated", err_count2, 3);
        sample(8'd1, 1'b1);
        check("t6_clr_count", err_count2, 0);
        check("t6_clr_pulse", err_pulse2, 1);
        idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/even_count_monitor.md
# even_count_monitor

Hardware checker for the receiving end of the even up-counter's `q` bus. Samples the counter output on qualified cycles, locks onto the even up-count sequence, and reports odd values, skipped/repeated steps and wrap-around. Sits beside the even counter in simulation and on-chip self-test, replacing software expected-value models with a synthesizable monitor.

## Interface
- `WIDTH`, 8: width of the monitored count bus.
- `STEP`, 2: expected increment per sample; even, 2 ≤ STEP < 2^WIDTH.
- `LOCK_COUNT`, 4: consecutive in-sequence samples, including the seed, needed to declare lock; ≥ 2.
- `ERR_CNT_W`, 8: width of the saturating error counter.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `valid`  in  1  `q` holds a new counter value this cycle.
- `q`  in  WIDTH  counter value under test.
- `clr_err`  in  1  synchronous clear of `err_count`.
- `locked`  out  1  monitor is tracking the sequence.
- `expected`  out  WIDTH  next value required from the counter.
- `odd_err`  out  1  one-cycle pulse: sampled `q` was odd.
- `seq_err`  out  1  one-cycle pulse: even `q` did not match `expected` while LOCKED.
- `err_pulse`  out  1  one-cycle pulse: any error counted (`odd_err` or `seq_err` while LOCKED).
- `wrap_pulse`  out  1  one-cycle pulse: LOCKED sample equal to 2^WIDTH − STEP accepted.
- `err_count`  out  ERR_CNT_W  saturating count of `err_pulse` events.

## Operation
- States: HUNT (no reference), CONFIRM (seeded, counting matches), LOCKED.
- Internal `match_cnt`, sized to hold LOCK_COUNT.
- Cycles with `valid` = 0: state, `expected`, `match_cnt` held; all pulse outputs 0.
- Odd test: `q[0]` = 1. An odd sample raises `odd_err` in every state.
- HUNT, valid:
  - even `q`: `expected` ← `q` + STEP mod 2^WIDTH, `match_cnt` ← 1, go to CONFIRM.
  - odd `q`: stay in HUNT.
- CONFIRM, valid:
  - `q` == `expected`: `expected` advances by STEP, `match_cnt` increments; when the new `match_cnt` equals LOCK_COUNT, go to LOCKED.
  - even mismatch: reseed from `q` (`expected` ← `q` + STEP, `match_cnt` ← 1), stay in CONFIRM.
  - odd: go to HUNT.
  - No `seq_err` and no error count in CONFIRM.
- LOCKED, valid:
  - `q` == `expected`: `expected` advances mod 2^WIDTH.
    - If `q` == 2^WIDTH − STEP, pulse `wrap_pulse`; stay LOCKED.
  - Even mismatch, including a repeated value or 0 after a counter reset:
    - pulse `seq_err` and `err_pulse`;
    - reseed as in CONFIRM and go to CONFIRM.
  - Odd: pulse `odd_err` and `err_pulse`, go to HUNT.
- `locked` = 1 exactly while in LOCKED.
- `err_count` increments by 1 on each `err_pulse` and saturates at 2^ERR_CNT_W − 1.
  - Odd samples outside LOCKED are not counted.
- `clr_err` takes priority: with a simultaneous error, `err_count` becomes 0 and the pulses still fire.
- `expected` holds its last value in HUNT.

## Timing
- All outputs are registered and update on the rising `clk` edge that samples `valid`/`q`.
  - Response is visible the cycle after the sample; latency is 1.
- Each pulse lasts exactly one cycle per triggering sample.
- Back-to-back valid samples are supported every cycle, with no stall.
- `reset` low asynchronously forces:
  - HUNT, `match_cnt` = 0, `expected` = 0, `err_count` = 0;
  - `locked`, `odd_err`, `seq_err`, `err_pulse`, `wrap_pulse` = 0.
- Release of `reset` is sampled at the next rising edge. The first valid sample after release is treated as a HUNT sample.
- Reset mid-stream discards lock and the error history.

## Test plan
All scenarios use WIDTH=8, STEP=2, LOCK_COUNT=4 unless stated.
1. Reset, then `valid`=1 with `q` = 0, 2, 4, 6 on consecutive cycles → `locked` rises one cycle after the sample 6, `expected` = 8, no error pulses, `err_count` = 0.
2. Lock at 248, then feed 250, 252, 254, 0, 2 → `wrap_pulse` one cycle after 254 only, `locked` stays 1, `expected` = 4.
3. LOCKED with `expected` = 20, feed 24 → `seq_err` and `err_pulse` for one cycle, `err_count` = 1, `locked` = 0, `expected` = 26. Then 26, 28, 30 → relock.
4. In HUNT, feed 7 → `odd_err` = 1, `err_count` unchanged, still HUNT. In LOCKED, feed 9 → `odd_err`, `err_pulse`, `err_count` + 1, HUNT.
5. Drive `reset` low mid-stream while LOCKED with `err_count` = 3 → all outputs 0 immediately, without a clock edge. After release, 0, 2, 4, 6 relocks.
6. ERR_CNT_W=2: cause 5 LOCKED errors → `err_count` = 3, saturated. Assert `clr_err` in the same cycle as a sixth error → `err_count` = 0 and `err_pulse` = 1.
